// File: rtl/dimmer_sequencer_pkg.sv
// Shared types for the lamp dimmer sequencer: FSM states and decoded sensor requests.
package dimmer_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_UP    = 3'd2,
    ST_DOWN  = 3'd3,
    ST_FORCE = 3'd4
  } dimmer_state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_UP   = 2'd1,
    REQ_DN   = 2'd2
  } dimmer_req_e;

  // Conflicting requests (both comparators firing) cancel each other out.
  function automatic dimmer_req_e decode_req(input logic aum, input logic dim);
    if (aum && !dim) return REQ_UP;
    if (dim && !aum) return REQ_DN;
    return REQ_NONE;
  endfunction

endpackage

// File: rtl/dimmer_sequencer_if.sv
// Control/status bundle between the comparator/timer logic and the dimmer sequencer.
interface dimmer_sequencer_if #(
  parameter int LEVEL_W = 4
);
  logic               enable;
  logic               dim_req;
  logic               aum_req;
  logic               timer_on;
  logic [LEVEL_W-1:0] level_max;
  logic [LEVEL_W-1:0] level;
  logic               pwm_out;
  logic               busy;
  logic               at_limit;

  modport master (
    output enable, dim_req, aum_req, timer_on, level_max,
    input  level, pwm_out, busy, at_limit
  );

  modport slave (
    input  enable, dim_req, aum_req, timer_on, level_max,
    output level, pwm_out, busy, at_limit
  );
endinterface

// File: rtl/dimmer_sequencer_tick_prescaler.sv
// Divides clk into a one-cycle tick every DIV cycles; counter parks at 0 while disabled.
module tick_prescaler #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick on the last count, then wrap; hold at zero when not enabled.
  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (!en || tick) cnt_d = '0;
    else             cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dimmer_sequencer.sv
// Lamp brightness sequencer: timer/sensor arbitration, debounced ramping and PWM drive.
module dimmer_sequencer #(
  parameter int LEVEL_W    = 4,
  parameter int TICK_DIV   = 1000,
  parameter int HOLD_TICKS = 8
) (
  input logic          clk,
  input logic          rst_n,
  dimmer_sequencer_if.slave bus
);
  import dimmer_sequencer_pkg::*;

  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

  dimmer_state_e      state_q, state_d;
  dimmer_req_e        req_q, req_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               pwm_q, pwm_d;
  logic               busy_q, busy_d;
  logic               at_limit_q, at_limit_d;
  logic               tick;
  logic               qualified;
  logic               req_up, req_dn;
  logic               exit_active;
  logic [LEVEL_W-1:0] lmax;

  assign lmax = bus.level_max;

  tick_prescaler #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.enable),
    .tick  (tick)
  );

  // Decode the comparator requests and flag a request that has been stable long enough.
  always_comb begin
    req_d     = decode_req(bus.aum_req, bus.dim_req);
    req_up    = (req_d == REQ_UP);
    req_dn    = (req_d == REQ_DN);
    qualified = (hold_q == HOLD_MAX);
  end

  // Next state and next level; disable beats timer, timer beats sensor requests.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (!bus.enable) begin
      state_d = ST_OFF;
      level_d = '0;
    end else if (bus.timer_on) begin
      state_d = ST_FORCE;
      level_d = lmax;
    end else begin
      unique case (state_q)
        ST_OFF: state_d = ST_IDLE;
        ST_IDLE: begin
          if (level_q > lmax)                          level_d = lmax;
          else if (qualified && req_up && level_q < lmax) state_d = ST_UP;
          else if (qualified && req_dn && level_q != '0)  state_d = ST_DOWN;
        end
        ST_UP: begin
          if (!req_up || lmax <= level_q) begin
            state_d = ST_IDLE;
            level_d = (level_q > lmax) ? lmax : level_q;
          end else if (tick) begin
            level_d = level_q + 1'b1;
            if (level_q + 1'b1 == lmax) state_d = ST_IDLE;
          end
        end
        ST_DOWN: begin
          if (!req_dn) begin
            state_d = ST_IDLE;
          end else if (tick) begin
            level_d = level_q - 1'b1;
            if (level_q == LEVEL_W'(1)) state_d = ST_IDLE;
          end
        end
        ST_FORCE: state_d = ST_IDLE;
        default:  state_d = ST_OFF;
      endcase
    end
  end

  // Debounce count: restarts on request change/null and whenever a ramp or forced window ends.
  always_comb begin
    exit_active = (state_q inside {ST_UP, ST_DOWN, ST_FORCE}) && (state_d != state_q);
    hold_d      = hold_q;
    if (exit_active || req_d == REQ_NONE || req_d != req_q) hold_d = '0;
    else if (tick && !qualified)                           hold_d = hold_q + 1'b1;
  end

  // PWM compare and status flags derived from next-state values so they line up with level.
  always_comb begin
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    pwm_d      = (state_d != ST_OFF) && (pwm_cnt_q < level_q);
    busy_d     = (state_d == ST_UP) || (state_d == ST_DOWN);
    at_limit_d = (level_d == '0) || (level_d == lmax);
  end

  // State, level, debounce, PWM and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      req_q      <= REQ_NONE;
      level_q    <= '0;
      hold_q     <= '0;
      pwm_cnt_q  <= '0;
      pwm_q      <= 1'b0;
      busy_q     <= 1'b0;
      at_limit_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      level_q    <= level_d;
      hold_q     <= hold_d;
      pwm_cnt_q  <= pwm_cnt_d;
      pwm_q      <= pwm_d;
      busy_q     <= busy_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign bus.level    = level_q;
  assign bus.pwm_out  = pwm_q;
  assign bus.busy     = busy_q;
  assign bus.at_limit = at_limit_q;
endmodule

// File: tb/tb_dimmer_sequencer.sv
// Self-checking bench for dimmer_sequencer: cycle model plus directed scenarios.
module tb_dimmer_sequencer;
  localparam int LEVEL_W    = 4;
  localparam int TICK_DIV   = 4;
  localparam int HOLD_TICKS = 2;
  localparam int PWM_PERIOD = 16;

  logic clk;
  logic rst_n;

  dimmer_sequencer_if #(.LEVEL_W(LEVEL_W)) bus ();

  dimmer_sequencer #(
    .LEVEL_W    (LEVEL_W),
    .TICK_DIV   (TICK_DIV),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the lamp: on/off, forced by timer, ramp direction (+1 up, -1 down, 0 hold).
  bit m_on, m_force, m_pwm, m_busy, m_atlim;
  int m_dir, m_level, m_phase, m_hold, m_last, m_pwmcnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic en, input logic aum, input logic dim,
                                input logic tmr, input int lmax);
    bus.enable    = en;
    bus.aum_req   = aum;
    bus.dim_req   = dim;
    bus.timer_on  = tmr;
    bus.level_max = LEVEL_W'(lmax);
  endtask

  task automatic model_step();
    int  req, lmax, nxt_dir, nxt_level, nxt_hold;
    bit  en, tmr, tick, qual, nxt_on, nxt_force, left;
    en   = bus.enable;
    tmr  = bus.timer_on;
    lmax = int'(bus.level_max);
    req  = (bus.aum_req && !bus.dim_req) ? 1 : (bus.dim_req && !bus.aum_req) ? -1 : 0;
    tick = en && (m_phase == TICK_DIV - 1);
    qual = (m_hold == HOLD_TICKS);
    nxt_on = m_on; nxt_force = m_force; nxt_dir = m_dir; nxt_level = m_level;
    if (!en) begin
      nxt_on = 0; nxt_force = 0; nxt_dir = 0; nxt_level = 0;
    end else if (tmr) begin
      nxt_on = 1; nxt_force = 1; nxt_dir = 0; nxt_level = lmax;
    end else if (!m_on) begin
      nxt_on = 1;
    end else if (m_force) begin
      nxt_force = 0;
    end else if (m_dir == 0) begin
      if (m_level > lmax) nxt_level = lmax;
      else if (qual && req == 1 && m_level < lmax) nxt_dir = 1;
      else if (qual && req == -1 && m_level > 0) nxt_dir = -1;
    end else if (m_dir == 1) begin
      if (req != 1 || lmax <= m_level) begin
        nxt_dir = 0;
        nxt_level = (m_level > lmax) ? lmax : m_level;
      end else if (tick) begin
        nxt_level = m_level + 1;
        if (nxt_level == lmax) nxt_dir = 0;
      end
    end else begin
      if (req != -1) nxt_dir = 0;
      else if (tick) begin
        nxt_level = m_level - 1;
        if (nxt_level == 0) nxt_dir = 0;
      end
    end
    left = m_on && (m_force || m_dir != 0) &&
           (nxt_on != m_on || nxt_force != m_force || nxt_dir != m_dir);
    nxt_hold = m_hold;
    if (left || req == 0 || req != m_last) nxt_hold = 0;
    else if (tick && m_hold < HOLD_TICKS)  nxt_hold = m_hold + 1;
    m_pwm    = nxt_on && (m_pwmcnt < m_level);
    m_pwmcnt = (m_pwmcnt + 1) % PWM_PERIOD;
    m_phase  = (!en || tick) ? 0 : m_phase + 1;
    m_busy   = nxt_on && !nxt_force && nxt_dir != 0;
    m_atlim  = (nxt_level == 0) || (nxt_level == lmax);
    m_hold   = nxt_hold;
    m_last   = req;
    m_on = nxt_on; m_force = nxt_force; m_dir = nxt_dir; m_level = nxt_level;
  endtask

  // Advance the model on the same edges as the design, including async reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on = 0; m_force = 0; m_dir = 0; m_level = 0; m_phase = 0; m_hold = 0;
      m_last = 0; m_pwmcnt = 0; m_pwm = 0; m_busy = 0; m_atlim = 1;
    end else begin
      model_step();
    end
  end

  // Compare every output against the model midway through each cycle.
  always @(negedge clk) begin
    check_output("model_level",    bus.level,    m_level);
    check_output("model_pwm_out",  bus.pwm_out,  m_pwm);
    check_output("model_busy",     bus.busy,     m_busy);
    check_output("model_at_limit", bus.at_limit, m_atlim);
  end

  task automatic wait_level(input int target, input int bound, input string name);
    int cyc;
    cyc = 0;
    while (int'(bus.level) != target && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    check_output(name, bus.level, target);
  endtask

  // Directed scenarios with hand-computed expectations.
  initial begin
    int cyc;
    int highs;
    int busy_seen;
    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 10);
    repeat (3) @(negedge clk);
    check_output("reset_level",    bus.level,    0);
    check_output("reset_pwm",      bus.pwm_out,  0);
    check_output("reset_busy",     bus.busy,     0);
    check_output("reset_at_limit", bus.at_limit, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] ramp up to level_max=10");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 10);
    cyc = 0;
    while (!bus.busy && cyc < 100) begin @(negedge clk); cyc++; end
    check_output("cycles_to_up", cyc, 9);
    while (bus.level != 4'd10 && cyc < 200) begin @(negedge clk); cyc++; end
    check_output("cycles_to_top", cyc, 48);
    check_output("top_level",    bus.level,    10);
    check_output("top_at_limit", bus.at_limit, 1);
    check_output("top_busy",     bus.busy,     0);

    $display("[TB] one-tick dim glitch then ramp down");
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 10);
    repeat (4) @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 10);
    repeat (12) @(negedge clk);
    check_output("glitch_level", bus.level, 10);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 10);
    wait_level(0, 200, "down_reach_zero");
    repeat (20) @(negedge clk);
    check_output("down_stay_zero", bus.level,    0);
    check_output("down_at_limit",  bus.at_limit, 1);
    check_output("down_busy",      bus.busy,     0);

    $display("[TB] timer priority");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 10);
    wait_level(3, 200, "up_to_three");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 10);
    @(negedge clk);
    check_output("force_level", bus.level, 10);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 6);
    @(negedge clk);
    check_output("force_track_max", bus.level, 6);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 6);
    repeat (20) @(negedge clk);
    check_output("force_exit_level", bus.level, 6);
    check_output("force_exit_busy",  bus.busy,  0);

    $display("[TB] conflicting requests and level_max boundaries");
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 10);
    repeat (40) @(negedge clk);
    check_output("conflict_level", bus.level, 6);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 10);
    wait_level(10, 200, "regain_top");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 10);
    repeat (3) @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4);
    @(negedge clk);
    check_output("clamp_level", bus.level, 4);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check_output("clamp_zero", bus.level, 0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 0);
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.busy) busy_seen = 1;
    end
    check_output("zero_max_level", bus.level, 0);
    check_output("zero_max_no_up", busy_seen, 0);

    $display("[TB] PWM duty and disable");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 4);
    wait_level(4, 200, "pwm_level_four");
    repeat (4) @(negedge clk);
    highs = 0;
    repeat (PWM_PERIOD) begin
      @(negedge clk);
      if (bus.pwm_out) highs++;
    end
    check_output("pwm_duty_4", highs, 4);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4);
    @(negedge clk);
    check_output("off_pwm",   bus.pwm_out, 0);
    check_output("off_level", bus.level,   0);
    highs = 0;
    repeat (PWM_PERIOD) begin
      @(negedge clk);
      if (bus.pwm_out) highs++;
    end
    check_output("off_pwm_window", highs, 0);

    $display("[TB] reset in the middle of a ramp");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 10);
    wait_level(5, 200, "up_to_five");
    check_output("mid_ramp_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst_level",    bus.level,    0);
    check_output("async_rst_pwm",      bus.pwm_out,  0);
    check_output("async_rst_busy",     bus.busy,     0);
    check_output("async_rst_at_limit", bus.at_limit, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
